// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: I-side and D-side L1 line ports plus the shared memory port.
// The slave modport is the arbiter's view; master is the L1s-plus-memory view.
interface mem_arbiter_if;
  logic         l1i_read;
  logic         l1i_write;
  logic [31:4]  l1i_addr;
  logic [127:0] l1i_wdata;
  logic [127:0] l1i_rdata;
  logic         l1i_ready;

  logic         l1d_read;
  logic         l1d_write;
  logic [31:4]  l1d_addr;
  logic [127:0] l1d_wdata;
  logic [127:0] l1d_rdata;
  logic         l1d_ready;

  logic         mem_read;
  logic         mem_write;
  logic [31:4]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  l1i_read, l1i_write, l1i_addr, l1i_wdata,
    output l1i_rdata, l1i_ready,
    input  l1d_read, l1d_write, l1d_addr, l1d_wdata,
    output l1d_rdata, l1d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output l1i_read, l1i_write, l1i_addr, l1i_wdata,
    input  l1i_rdata, l1i_ready,
    output l1d_read, l1d_write, l1d_addr, l1d_wdata,
    input  l1d_rdata, l1d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (I-side read-only, D-side read/write) line arbiter onto one memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D priority.
module mem_arbiter (
  input  logic          clk,
  input  logic          proc_reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;

  // grant_p1: bit 1 = D-side, bit 0 = I-side; all-zero when nobody is being served
  logic [1:0]   grant_p1;
  logic         op_wr_p1;
  logic [31:4]  addr_p1;
  logic [127:0] wdata_p1;

  logic [1:0]   grant_nxt;
  logic         op_wr_nxt;
  logic [31:4]  addr_nxt;
  logic [127:0] wdata_nxt;

  logic         d_req;
  logic         i_req;
  logic         pick_d;
  logic         done;
  logic         unused_ok;

  assign d_req = bus.l1d_read | bus.l1d_write;
  assign i_req = bus.l1i_read;
  assign done  = (state_q == BUSY) && bus.mem_ready;

  // The I-side never writes, so its write strobe and write data are dead inputs.
  assign unused_ok = ^{bus.l1i_write, bus.l1i_wdata};

`ifdef ARB_ROUND_ROBIN_EN
  logic prio_d_q;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      prio_d_q <= 1'b1;
    end else if (done) begin
      prio_d_q <= grant_p1[0];
    end
  end

  assign pick_d = d_req && (!i_req || prio_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    grant_nxt = grant_p1;
    op_wr_nxt = op_wr_p1;
    addr_nxt  = addr_p1;
    wdata_nxt = wdata_p1;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          state_d = BUSY;
          if (pick_d) begin
            // A combined write+read is served as the write-back first; the read stays pending.
            grant_nxt = 2'b10;
            op_wr_nxt = bus.l1d_write;
            addr_nxt  = bus.l1d_addr;
            wdata_nxt = bus.l1d_wdata;
          end else begin
            grant_nxt = 2'b01;
            op_wr_nxt = 1'b0;
            addr_nxt  = bus.l1i_addr;
            wdata_nxt = bus.l1i_wdata;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d   = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_d   = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // Command register stage: everything the memory sees is launched from here.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      grant_p1 <= 2'b00;
      op_wr_p1 <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      state_q  <= state_d;
      grant_p1 <= grant_nxt;
      op_wr_p1 <= op_wr_nxt;
      addr_p1  <= addr_nxt;
      wdata_p1 <= wdata_nxt;
    end
  end

  assign bus.mem_read  = (state_q == BUSY) && !op_wr_p1;
  assign bus.mem_write = (state_q == BUSY) &&  op_wr_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;

  assign bus.l1i_ready = done && grant_p1[0];
  assign bus.l1d_ready = done && grant_p1[1];
  assign bus.l1i_rdata = bus.mem_rdata;
  assign bus.l1d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized request traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit prio_d   = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_read"},  bus.mem_read,  1'b0);
    chk({tag, "_mem_write"}, bus.mem_write, 1'b0);
    chk({tag, "_l1i_ready"}, bus.l1i_ready, 1'b0);
    chk({tag, "_l1d_ready"}, bus.l1d_ready, 1'b0);
  endtask

  function automatic bit model_pick_d(input bit dreq, input bit ireq);
`ifdef ARB_ROUND_ROBIN_EN
    return dreq && (!ireq || prio_d);
`else
    return dreq;
`endif
  endfunction

  task automatic clear_served(input bit serve_d, input bit was_wr);
    if (serve_d) begin
      if (was_wr) bus.l1d_write = 1'b0;
      else        bus.l1d_read  = 1'b0;
    end else begin
      bus.l1i_read = 1'b0;
    end
  endtask

  task automatic chk_cmd(input string tag, input bit exp_wr, input logic [31:4] exp_addr,
                         input logic [127:0] exp_wd);
    chk({tag, "_mem_read"},  bus.mem_read,  !exp_wr);
    chk({tag, "_mem_write"}, bus.mem_write, exp_wr);
    chk({tag, "_mem_addr"},  bus.mem_addr,  exp_addr);
    if (exp_wr) chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wd);
  endtask

  // Called just after a negedge with requests already driven; the arbiter must be in IDLE.
  // Serves one transaction: wait_n BUSY cycles without mem_ready, one completion cycle, one DRAIN.
  task automatic txn(input int wait_n, input bit drop_mid, input bit keep);
    bit           serve_d;
    bit           exp_wr;
    logic [31:4]  exp_addr;
    logic [127:0] exp_wd;
    logic [127:0] rd;
    serve_d  = model_pick_d(bus.l1d_read | bus.l1d_write, bus.l1i_read);
    exp_wr   = serve_d && bus.l1d_write;
    exp_addr = serve_d ? bus.l1d_addr : bus.l1i_addr;
    exp_wd   = bus.l1d_wdata;
    bus.mem_ready = 1'b0;
    #1 chk_quiet("idle");
    for (int k = 0; k < wait_n; k++) begin
      @(negedge clk);
      if (drop_mid) begin
        if (k == 0) clear_served(serve_d, exp_wr);
        if (serve_d) begin bus.l1d_addr = 28'($urandom); bus.l1d_wdata = {4{$urandom}}; end
        else         bus.l1i_addr = 28'($urandom);
      end
      #1;
      chk_cmd("busy", exp_wr, exp_addr, exp_wd);
      chk("busy_l1i_ready", bus.l1i_ready, 1'b0);
      chk("busy_l1d_ready", bus.l1d_ready, 1'b0);
    end
    @(negedge clk);
    if (drop_mid && wait_n == 0) clear_served(serve_d, exp_wr);
    rd = {$urandom, $urandom, $urandom, $urandom};
    bus.mem_rdata = rd;
    bus.mem_ready = 1'b1;
    #1;
    chk_cmd("done", exp_wr, exp_addr, exp_wd);
    chk("done_l1i_ready", bus.l1i_ready, !serve_d);
    chk("done_l1d_ready", bus.l1d_ready, serve_d);
    chk("done_l1i_rdata", bus.l1i_rdata, rd);
    chk("done_l1d_rdata", bus.l1d_rdata, rd);
    @(negedge clk);
    bus.mem_ready = 1'($urandom);
    if (!keep) clear_served(serve_d, exp_wr);
    #1 chk_quiet("drain");
    bus.mem_ready = 1'b0;
    prio_d = !serve_d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_quiet(tag);
    chk({tag, "_mem_addr"},  bus.mem_addr,  28'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 128'h0);
  endtask

  initial begin
    bus.l1i_read  = 1'b0; bus.l1i_write = 1'b0; bus.l1i_addr = '0; bus.l1i_wdata = '0;
    bus.l1d_read  = 1'b0; bus.l1d_write = 1'b0; bus.l1d_addr = '0; bus.l1d_wdata = '0;
    bus.mem_rdata = '0;   bus.mem_ready = 1'b1;
    proc_reset = 1'b1;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    proc_reset = 1'b0;
    bus.mem_ready = 1'b0;

    // Lone I-side read, memory answers on the fourth BUSY cycle.
    @(negedge clk);
    bus.l1i_read = 1'b1; bus.l1i_addr = 28'h0000010;
    txn(3, 1'b0, 1'b0);

    // Simultaneous reads: D first, then I.
    @(negedge clk);
    bus.l1i_read = 1'b1; bus.l1i_addr = 28'h0000100;
    bus.l1d_read = 1'b1; bus.l1d_addr = 28'h0000200;
    txn(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("pending_i_kept", bus.l1i_read, 1'b1);
    txn(1, 1'b0, 1'b0);

    // Write-back with refill pending on the same line.
    @(negedge clk);
    bus.l1d_write = 1'b1; bus.l1d_read = 1'b1;
    bus.l1d_addr  = 28'h0000020; bus.l1d_wdata = {16{8'hA5}};
    txn(2, 1'b0, 1'b0);
    @(negedge clk);
    txn(0, 1'b0, 1'b0);

    // Reset in the middle of a transaction.
    @(negedge clk);
    bus.l1i_read = 1'b1; bus.l1i_addr = 28'h0000333;
    #1 chk_quiet("rstmid_idle");
    @(negedge clk);
    #1 chk("rstmid_busy_read", bus.mem_read, 1'b1);
    @(negedge clk);
    proc_reset = 1'b1; bus.mem_ready = 1'b1;
    #1 chk_reset_outputs("rstmid");
    @(negedge clk);
    proc_reset = 1'b0; bus.l1i_read = 1'b0;
    prio_d = 1'b1;
    #1 chk_quiet("rstmid_release");
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk_quiet("rstmid_after");

    // Both sides requesting continuously for four transactions.
    @(negedge clk);
    bus.l1i_read = 1'b1; bus.l1i_addr = 28'h0000044;
    bus.l1d_read = 1'b1; bus.l1d_addr = 28'h0000055;
    for (int t = 0; t < 4; t++) begin
      if (t > 0) @(negedge clk);
      txn(1, 1'b0, 1'b1);
    end
    bus.l1i_read = 1'b0; bus.l1d_read = 1'b0;

    // Spurious memory completion while idle.
    @(negedge clk);
    bus.mem_ready = 1'b1;
    #1 chk_quiet("spurious");
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1 chk_quiet("spurious_after");

    // Randomized traffic: requests accumulate and are served one transaction at a time.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.l1i_write = 1'($urandom);
      bus.l1i_wdata = {$urandom, $urandom, $urandom, $urandom};
      if (!bus.l1i_read && ($urandom_range(0, 2) == 0)) begin
        bus.l1i_read = 1'b1; bus.l1i_addr = 28'($urandom);
      end
      if (!bus.l1d_read && !bus.l1d_write && ($urandom_range(0, 2) == 0)) begin
        bus.l1d_read  = 1'($urandom);
        bus.l1d_write = !bus.l1d_read || ($urandom_range(0, 1) == 0);
        bus.l1d_addr  = 28'($urandom);
        bus.l1d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!bus.l1i_read && !bus.l1d_read && !bus.l1d_write) begin
        bus.mem_ready = 1'b1;
        #1 chk_quiet("rnd_idle");
      end else begin
        txn($urandom_range(0, 4), ($urandom_range(0, 3) == 0), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-002 SHALL have port proc_reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports l1i_read / l1i_write, input, 1 each, I-side line request (l1i_write ignored, read-only requester).
REQ-004 SHALL have ports l1i_addr, input, [31:4], and l1i_wdata, input, 128, I-side line address and unused write data.
REQ-005 SHALL have ports l1i_rdata, output, 128, and l1i_ready, output, 1, I-side returned line and completion strobe.
REQ-006 SHALL have ports l1d_read / l1d_write, input, 1 each, D-side refill / write-back request.
REQ-007 SHALL have ports l1d_addr, input, [31:4], and l1d_wdata, input, 128, D-side line address and write-back data.
REQ-008 SHALL have ports l1d_rdata, output, 128, and l1d_ready, output, 1, D-side returned line and completion strobe.
REQ-009 SHALL have ports mem_read / mem_write, output, 1 each, shared memory command.
REQ-010 SHALL have ports mem_addr, output, [31:4], and mem_wdata, output, 128, shared memory address and write data.
REQ-011 SHALL have ports mem_rdata, input, 128, and mem_ready, input, 1, memory read data and completion.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, DRAIN; reset state IDLE.
REQ-013 IDLE: any pending request SHALL be granted; grant, op, mem_addr, mem_wdata registered; next state BUSY; mem_read/mem_write asserted from the first BUSY cycle (1-cycle request-to-memory latency).
REQ-014 IDLE with no request SHALL hold mem_read=0, mem_write=0 and stay IDLE.
REQ-015 BUSY: mem_read, mem_write, mem_addr, mem_wdata SHALL stay stable until the cycle mem_ready=1.
REQ-016 On BUSY with mem_ready=1: granted requester's ready SHALL be 1 that same cycle (combinational: mem_ready AND grant AND BUSY); non-granted ready SHALL be 0; next state DRAIN.
REQ-017 l1i_rdata and l1d_rdata SHALL both pass mem_rdata directly; validity is qualified only by the respective ready.
REQ-018 DRAIN: lasts exactly 1 cycle, mem_read=mem_write=0, no grant, lets the served L1 drop its request; next state IDLE.
REQ-019 D-side with l1d_write=1 and l1d_read=1 together SHALL be serviced as write (mem_write=1, mem_read=0); the read stays pending and is arbitrated again afterwards.
REQ-020 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-021 A request deasserted by its requester while BUSY SHALL NOT abort the transaction; the arbiter completes it and still pulses ready.
REQ-022 Default arbitration (macro undefined): fixed priority, D-side wins on simultaneous requests.
REQ-023 mem_ready=1 outside BUSY SHALL be ignored (no ready pulse, no state change).

Reset
REQ-024 proc_reset=1 SHALL immediately force IDLE, grant cleared, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, l1i_ready=0, l1d_ready=0, round-robin pointer = D-side.
REQ-025 Reset asserted in BUSY SHALL abandon the transaction; no ready pulse after release; arbitration restarts from IDLE.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: simultaneous I/D requests in IDLE SHALL be granted to the requester not served last (1-bit pointer updated on each completion); undefined: fixed D-priority per REQ-022, no pointer flop.

Verification
REQ-027 Reset, then l1i_read=1 addr 0x0000010 alone; mem_ready after 4 cycles -> mem_read=1, mem_addr=0x0000010 from cycle 1, l1i_ready=1 on the mem_ready cycle, DRAIN then IDLE.
REQ-028 l1i_read and l1d_read both 1 in IDLE, fixed priority -> D served first, I served after D's DRAIN; l1i_ready never 1 during D transaction.
REQ-029 ARB_ROUND_ROBIN_EN defined, both requesters continuously requesting -> grants alternate D, I, D, I over 4 transactions.
REQ-030 l1d_write=1, l1d_read=1, wdata=128'hA5..A5, addr 0x0000020 -> mem_write=1 with that data, then after DRAIN mem_read=1 same addr; mem_read/mem_write never both 1.
REQ-031 proc_reset pulsed mid-BUSY, then mem_ready=1 -> all outputs 0 during reset, no ready pulse, FSM IDLE.
REQ-032 Spurious mem_ready=1 in IDLE with no request -> no ready pulse, mem_read=mem_write=0.
